enum_sequencer: RTL and testbench

//   Parametrised enumeration stepper for the waveform example set. Emits a stream
//   of enum codes 0..COUNT-1 over a valid/ready interface, replacing hand-written
//   per-clock enum assignment sequences. Supports four step modes and a

---
 rtl/enum_sequencer.sv | 164 ++++++++++++++++
 tb/tb_enum_sequencer.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/enum_sequencer.sv
// Enumeration stepper: emits codes 0..COUNT-1 over a valid/ready interface
// with four step modes (up-wrap, down-wrap, ping-pong, single-shot up) and a
// programmable per-code dwell. Mode and dwell are captured at start.
module enum_sequencer #(
    parameter int WIDTH = 3,
    parameter int COUNT = 5,
    parameter int DWW   = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             stop,
    input  logic [1:0]       mode,
    input  logic [DWW-1:0]   dwell,
    output logic             out_vld,
    input  logic             out_rdy,
    output logic [WIDTH-1:0] out_val,
    output logic             out_first,
    output logic             out_last,
    output logic             busy,
    output logic             done
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        M_UP   = 2'b00,
        M_DOWN = 2'b01,
        M_PING = 2'b10,
        M_SHOT = 2'b11
    } mode_t;

    // Codes wrap modulo COUNT, so both end codes must be representable.
    generate
        if (COUNT < 2 || COUNT > (1 << WIDTH)) begin : g_bad_count
            $error("enum_sequencer: COUNT must lie in 2..2**WIDTH");
        end
    endgenerate

    localparam logic [WIDTH-1:0] LAST = WIDTH'(COUNT - 1);
    localparam logic [WIDTH-1:0] ZERO = '0;

    state_t           state_q, state_n;
    mode_t            mode_q, mode_n;
    logic [DWW-1:0]   dwell_q, dwell_n;
    logic [DWW-1:0]   cnt_q, cnt_n;
    logic [WIDTH-1:0] val_q, val_n;
    logic             dir_up_q, dir_up_n;
    logic             stop_q, stop_n;

    logic             stop_hit;
    logic             code_end;
    logic             final_xfer;

    // State register with synchronous active-low reset.
    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments keep every register sampling the
        // pre-edge values, so ordering inside this block does not matter.
        if (!rst_n) begin
            state_q  <= S_IDLE;
            mode_q   <= M_UP;
            dwell_q  <= '0;
            cnt_q    <= '0;
            val_q    <= '0;
            dir_up_q <= 1'b1;
            stop_q   <= 1'b0;
        end else begin
            state_q  <= state_n;
            mode_q   <= mode_n;
            dwell_q  <= dwell_n;
            cnt_q    <= cnt_n;
            val_q    <= val_n;
            dir_up_q <= dir_up_n;
            stop_q   <= stop_n;
        end
    end

    // Next-state, code stepping, dwell counting and stop latching.
    always_comb begin
        // NOTE: every variable gets a default before the case so that no
        // path leaves one unassigned, which would infer a latch.
        state_n  = state_q;
        mode_n   = mode_q;
        dwell_n  = dwell_q;
        cnt_n    = cnt_q;
        val_n    = val_q;
        dir_up_n = dir_up_q;
        stop_n   = stop_q;

        stop_hit   = stop_q | stop;
        code_end   = (cnt_q == dwell_q);
        final_xfer = (mode_q == M_SHOT) && code_end && (val_q == LAST);

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_n  = S_RUN;
                    mode_n   = mode_t'(mode);
                    dwell_n  = dwell;
                    cnt_n    = '0;
                    val_n    = (mode_t'(mode) == M_DOWN) ? LAST : ZERO;
                    dir_up_n = 1'b1;
                    stop_n   = 1'b0;
                end
            end

            S_RUN: begin
                stop_n = stop_hit;
                if (out_rdy) begin
                    if (final_xfer || stop_hit) begin
                        // Single-shot completion outranks a pending stop.
                        state_n = final_xfer ? S_DONE : S_IDLE;
                        stop_n  = 1'b0;
                        cnt_n   = '0;
                    end else if (!code_end) begin
                        // Compare happens before the increment, so the
                        // counter never exceeds dwell and cannot wrap.
                        cnt_n = cnt_q + 1'b1;
                    end else begin
                        cnt_n = '0;
                        case (mode_q)
                            M_UP:   val_n = (val_q == LAST) ? ZERO : val_q + 1'b1;
                            M_DOWN: val_n = (val_q == ZERO) ? LAST : val_q - 1'b1;
                            M_PING: begin
                                if (dir_up_q) begin
                                    if (val_q == LAST) begin
                                        val_n    = val_q - 1'b1;
                                        dir_up_n = 1'b0;
                                    end else begin
                                        val_n = val_q + 1'b1;
                                    end
                                end else begin
                                    if (val_q == ZERO) begin
                                        val_n    = val_q + 1'b1;
                                        dir_up_n = 1'b1;
                                    end else begin
                                        val_n = val_q - 1'b1;
                                    end
                                end
                            end
                            default: val_n = val_q + 1'b1;
                        endcase
                    end
                end
            end

            S_DONE: state_n = S_IDLE;

            default: state_n = S_IDLE;
        endcase
    end

    assign out_vld   = (state_q == S_RUN);
    assign busy      = (state_q == S_RUN);
    assign done      = (state_q == S_DONE);
    assign out_val   = val_q;
    assign out_first = out_vld & (val_q == ZERO);
    assign out_last  = out_vld & (val_q == LAST);

endmodule

// File: tb/tb_enum_sequencer.sv
// Self-checking bench for enum_sequencer: a transfer-count model predicts the
// code stream from closed-form rules per mode; directed scenarios pin the
// model with literal sequences. A second instance covers COUNT = 2**WIDTH.
module tb_enum_sequencer;

    localparam int C = 5;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic       stop = 1'b0;
    logic [1:0] mode = 2'b00;
    logic [3:0] dwell = 4'd0;
    logic       out_rdy = 1'b1;

    logic       out_vld, out_first, out_last, busy, done;
    logic [2:0] out_val;

    logic       start8 = 1'b0;
    logic       stop8 = 1'b0;
    logic       vld8, first8, last8, busy8, done8;
    logic [2:0] val8;

    int checks = 0;
    int errors = 0;

    int q[$];
    int q8[$];
    int done_cnt = 0;

    // Model state: running flag, done pulse, transfers since start, latched config.
    int m_busy = 0;
    int m_done = 0;
    int m_k = 0;
    int m_mode = 0;
    int m_dwell = 0;
    int m_stop = 0;

    enum_sequencer #(.WIDTH(3), .COUNT(C), .DWW(4)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .stop(stop), .mode(mode),
        .dwell(dwell), .out_vld(out_vld), .out_rdy(out_rdy), .out_val(out_val),
        .out_first(out_first), .out_last(out_last), .busy(busy), .done(done)
    );

    enum_sequencer #(.WIDTH(3), .COUNT(8), .DWW(4)) dut8 (
        .clk(clk), .rst_n(rst_n), .start(start8), .stop(stop8), .mode(2'b00),
        .dwell(4'd0), .out_vld(vld8), .out_rdy(out_rdy), .out_val(val8),
        .out_first(first8), .out_last(last8), .busy(busy8), .done(done8)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic check_seq(input string name, input int exp[$]);
        check({name, " len"}, int'(q.size() >= exp.size()), 1);
        for (int i = 0; i < exp.size(); i++)
            if (i < q.size()) check($sformatf("%s[%0d]", name, i), q[i], exp[i]);
    endtask

    // n-th distinct code of a run, from the step rules of each mode.
    function automatic int model_code(input int md, input int n);
        int p;
        case (md)
            0: return n % C;
            1: return C - 1 - (n % C);
            2: begin
                p = n % (2 * C - 2);
                return (p < C) ? p : 2 * C - 2 - p;
            end
            default: return n;
        endcase
    endfunction

    // Model update: counts transfers and decides when a run ends.
    always @(posedge clk) begin
        if (!rst_n) begin
            m_busy = 0; m_done = 0; m_k = 0; m_stop = 0;
        end else if (m_done != 0) begin
            m_done = 0;
        end else if (m_busy == 0) begin
            if (start) begin
                m_busy = 1; m_k = 0; m_stop = 0;
                m_mode = int'(mode); m_dwell = int'(dwell);
            end
        end else begin
            if (out_rdy) begin
                if (m_mode == 3 && m_k == C * (m_dwell + 1) - 1) begin
                    m_busy = 0; m_done = 1;
                end else if (m_stop != 0 || stop) begin
                    m_busy = 0;
                end else begin
                    m_k++;
                end
            end else if (stop) begin
                m_stop = 1;
            end
        end
    end

    // Compare process: DUT outputs against the model every cycle.
    always @(negedge clk) begin
        int ev;
        check("out_vld", out_vld, m_busy);
        check("busy", busy, m_busy);
        check("done", done, m_done);
        if (m_busy != 0) begin
            ev = model_code(m_mode, m_k / (m_dwell + 1));
            check("out_val", out_val, ev);
            check("out_first", out_first, int'(ev == 0));
            check("out_last", out_last, int'(ev == C - 1));
        end else begin
            check("out_first idle", out_first, 0);
            check("out_last idle", out_last, 0);
        end
    end

    // Transfer and done recorders for the literal sequence checks.
    always @(negedge clk) begin
        if (out_vld && out_rdy) q.push_back(int'(out_val));
        if (done) done_cnt++;
        if (vld8 && out_rdy) q8.push_back(int'(val8));
    end

    initial begin
        int e[$];
        int d0;

        tick(2);
        check("reset vld", out_vld, 0);
        check("reset busy", busy, 0);
        check("reset done", done, 0);
        check("reset val", out_val, 0);
        check("reset vld8", vld8, 0);
        rst_n = 1'b1;
        tick(1);

        // 1: up-wrap, full rate.
        q.delete();
        mode = 2'b00; dwell = 4'd0; out_rdy = 1'b1;
        start = 1'b1; tick(1); start = 1'b0;
        tick(7);
        e = '{0, 1, 2, 3, 4, 0, 1};
        check_seq("t1 seq", e);
        stop = 1'b1; tick(1); stop = 1'b0;
        tick(2);
        check("t1 stopped busy", busy, 0);

        // 2: ping-pong with dwell 1; config changes after start are ignored.
        q.delete();
        mode = 2'b10; dwell = 4'd1;
        start = 1'b1; tick(1); start = 1'b0;
        mode = 2'b00; dwell = 4'd3;
        tick(20);
        e = '{0, 0, 1, 1, 2, 2, 3, 3, 4, 4, 3, 3, 2, 2, 1, 1, 0, 0, 1, 1};
        check_seq("t2 seq", e);
        stop = 1'b1; tick(1); stop = 1'b0;
        tick(2);
        check("t2 stopped busy", busy, 0);

        // 3: single-shot with out_rdy toggling.
        q.delete();
        d0 = done_cnt;
        mode = 2'b11; dwell = 4'd0; out_rdy = 1'b0;
        start = 1'b1; tick(1); start = 1'b0;
        for (int i = 0; i < 12; i++) begin
            out_rdy = (i % 2 == 0);
            tick(1);
        end
        out_rdy = 1'b1;
        check("t3 busy after", busy, 0);
        check("t3 done pulses", done_cnt - d0, 1);
        check("t3 len", q.size(), 5);
        e = '{0, 1, 2, 3, 4};
        check_seq("t3 seq", e);

        // 4: down-wrap, stop held while stalled on code 2.
        q.delete();
        d0 = done_cnt;
        mode = 2'b01; dwell = 4'd0; out_rdy = 1'b1;
        start = 1'b1; tick(1); start = 1'b0;
        tick(2);
        out_rdy = 1'b0; stop = 1'b1;
        tick(3);
        check("t4 hold val", out_val, 2);
        check("t4 hold busy", busy, 1);
        out_rdy = 1'b1;
        tick(1);
        stop = 1'b0;
        check("t4 idle busy", busy, 0);
        check("t4 len", q.size(), 3);
        e = '{4, 3, 2};
        check_seq("t4 seq", e);
        check("t4 no done", done_cnt - d0, 0);
        start = 1'b1; tick(1); start = 1'b0;
        check("t4 restart val", out_val, 4);
        stop = 1'b1; tick(1); stop = 1'b0;
        tick(1);

        // 5: start/mode ignored mid-run, then reset aborts.
        q.delete();
        d0 = done_cnt;
        mode = 2'b00; dwell = 4'd0; out_rdy = 1'b1;
        start = 1'b1; tick(1); start = 1'b0;
        tick(1);
        mode = 2'b01; start = 1'b1;
        tick(2);
        check("t5 val mid-run", out_val, 3);
        check("t5 busy mid-run", busy, 1);
        start = 1'b0; rst_n = 1'b0;
        tick(1);
        rst_n = 1'b1;
        check("t5 rst vld", out_vld, 0);
        check("t5 rst busy", busy, 0);
        check("t5 rst done", done, 0);
        check("t5 rst val", out_val, 0);
        check("t5 rst first", out_first, 0);
        tick(2);
        check("t5 no done", done_cnt - d0, 0);
        mode = 2'b00;

        // 6: COUNT = 2**WIDTH wraps 7 -> 0.
        q8.delete();
        start8 = 1'b1; tick(1); start8 = 1'b0;
        tick(10);
        e = '{0, 1, 2, 3, 4, 5, 6, 7, 0, 1};
        check("t6 len", int'(q8.size() >= e.size()), 1);
        for (int i = 0; i < e.size(); i++)
            if (i < q8.size()) check($sformatf("t6 seq[%0d]", i), q8[i], e[i]);
        stop8 = 1'b1; tick(1); stop8 = 1'b0;
        tick(1);
        check("t6 stopped busy", busy8, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
